// File: rtl/pal_cfg_pkg.sv
// pal_cfg_pkg -- shared definitions for the PAL configuration loader.
//   * cfg_state_e      : loader FSM states
//   * bitstream_len()  : config bitstream length for a PAL geometry, also
//                        used by the PAL top wrapper so both sides agree
//   * CRC8_POLY        : CRC-8 polynomial (x^8 + x^2 + x + 1)
//   * UIO_CFG_*        : PAL uio_in pin indices fed by the loader
package pal_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    HIGH,
    SETTLE,
    DONE
  } cfg_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  localparam int UIO_CFG_DATA = 0;
  localparam int UIO_CFG_EN   = 1;
  localparam int UIO_CFG_CLK  = 2;

  // Two literal columns per input per product-term stage, plus one OR-plane
  // connection per stage per output.
  function automatic int bitstream_len(input int num_inputs,
                                       input int num_outputs,
                                       input int num_stages);
    return 2 * num_inputs * num_stages + num_stages * num_outputs;
  endfunction

endpackage

// File: rtl/pal_cfg_crc8.sv
// pal_cfg_crc8 -- bit-serial CRC-8 register (poly 0x07, init 0x00,
// MSB-first / non-reflected). One message bit is folded in per enabled cycle.
// Ports:
//   clk    in  : clock, rising edge
//   rst    in  : synchronous active-high reset (clears CRC)
//   clr    in  : synchronous clear back to the 0x00 seed
//   en     in  : fold bit_in into the CRC this cycle
//   bit_in in  : message bit
//   crc    out : current CRC value (registered)
module pal_cfg_crc8
  import pal_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 8'h00;
    end else if (en) begin
      // Feedback is the outgoing MSB xor the incoming message bit.
      crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ bit_in) ? CRC8_POLY : 8'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader -- streams a PAL configuration bitstream from a byte-wide
// valid/ready interface onto the PAL serial config pins (LSB of each byte
// first), then raises the PAL enable once the bitstream has settled.
// Optional feature macro: PAL_CFG_CRC_EN (CRC-8 over the shifted bits);
// when undefined, crc is tied to zero.
// Ports:
//   clk      in      : system clock, rising edge
//   rst      in      : synchronous active-high reset
//   start    in      : one-cycle pulse, begins a load (from IDLE or DONE)
//   run      in      : user gate for the PAL enable
//   s_data   in  [8] : bitstream byte, bit 0 shifted first
//   s_valid  in      : byte valid
//   s_ready  out     : loader accepts a byte this cycle
//   cfg_data out     : PAL config data  (uio_in[0])
//   cfg_en   out     : PAL enable       (uio_in[1]) = done & run
//   cfg_clk  out     : PAL config clock (uio_in[2])
//   busy     out     : load in progress
//   done     out     : bitstream fully shifted and settled
//   crc      out [8] : CRC-8 of the shifted bits
module pal_cfg_loader
  import pal_cfg_pkg::*;
#(
  parameter int NUM_INPUTS        = 8,
  parameter int NUM_OUTPUTS       = 4,
  parameter int NUM_INTERM_STAGES = 14,
  parameter int CLK_DIV           = 2,
  parameter int SETTLE_CYCLES     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       run,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       cfg_data,
  output logic       cfg_en,
  output logic       cfg_clk,
  output logic       busy,
  output logic       done,
  output logic [7:0] crc
);

  localparam int BITSTREAM_LEN = bitstream_len(NUM_INPUTS, NUM_OUTPUTS, NUM_INTERM_STAGES);
  localparam int CNT_W         = $clog2(BITSTREAM_LEN + 1);
  // One phase counter serves the low, high and settle intervals.
  localparam int PHASE_MAX     = (CLK_DIV > SETTLE_CYCLES) ? CLK_DIV : SETTLE_CYCLES;
  localparam int PH_W          = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  localparam logic [CNT_W-1:0] LEN_C       = CNT_W'(BITSTREAM_LEN);
  localparam logic [PH_W-1:0]  DIV_LAST    = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);

  cfg_state_e       state_q,    state_d;
  logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [2:0]       bit_idx_q,  bit_idx_d;
  logic [7:0]       shreg_q,    shreg_d;
  logic [PH_W-1:0]  phase_q,    phase_d;
  logic             cfg_data_q, cfg_data_d;
  logic             cfg_clk_q,  cfg_clk_d;
  logic             s_ready_q,  s_ready_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    phase_d    = phase_q;
    cfg_data_d = cfg_data_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          phase_d   = '0;
          state_d   = LOAD;
        end
      end

      LOAD: begin
        if (s_valid && s_ready_q) begin
          shreg_d    = s_data;
          bit_idx_d  = '0;
          phase_d    = '0;
          // Data is presented as SETUP is entered, while cfg_clk is low.
          cfg_data_d = s_data[0];
          state_d    = SETUP;
        end
      end

      SETUP: begin
        // Shift register bit 0 already equals cfg_data here; restating it
        // keeps the pin tied to the register it mirrors.
        cfg_data_d = shreg_q[0];
        if (phase_q == DIV_LAST) begin
          phase_d = '0;
          state_d = HIGH;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      HIGH: begin
        cfg_data_d = shreg_q[0];
        if (phase_q == DIV_LAST) begin
          phase_d   = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          bit_idx_d = bit_idx_q + 1'b1;
          shreg_d   = {1'b0, shreg_q[7:1]};
          // Terminal count wins over the byte boundary, so unused tail bits
          // of the last byte are dropped without a clock pulse.
          if (bit_cnt_d == LEN_C) begin
            state_d = SETTLE;
          end else if (bit_idx_q == 3'd7) begin
            state_d = LOAD;
          end else begin
            cfg_data_d = shreg_q[1];
            state_d    = SETUP;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      SETTLE: begin
        if (phase_q == SETTLE_LAST) begin
          phase_d = '0;
          state_d = DONE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step
    // with the state they describe.
    s_ready_d = (state_d == LOAD);
    cfg_clk_d = (state_d == HIGH);
    busy_d    = (state_d inside {LOAD, SETUP, HIGH, SETTLE});
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      phase_q    <= '0;
      cfg_data_q <= 1'b0;
      cfg_clk_q  <= 1'b0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      phase_q    <= phase_d;
      cfg_data_q <= cfg_data_d;
      cfg_clk_q  <= cfg_clk_d;
      s_ready_q  <= s_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef PAL_CFG_CRC_EN
  logic crc_clr;
  logic crc_en;

  // Seed on the accepted start; fold in the bit being clocked on each
  // HIGH exit. The final value then holds through DONE.
  assign crc_clr = start && ((state_q == IDLE) || (state_q == DONE));
  assign crc_en  = (state_q == HIGH) && (phase_q == DIV_LAST);

  pal_cfg_crc8 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (shreg_q[0]),
    .crc    (crc)
  );
`else
  assign crc = 8'h00;
`endif

  assign s_ready  = s_ready_q;
  assign cfg_data = cfg_data_q;
  assign cfg_clk  = cfg_clk_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cfg_en   = done_q & run;

endmodule
